// File: rtl/brush_stamp_ctrl.sv
// rtl/brush_stamp_ctrl.sv - brush stamp / canvas clear sequencer sharing the framebuffer port with VGA reads
`timescale 1ns/1ps
module brush_stamp_ctrl #(
  parameter int                 FB_W     = 160,
  parameter int                 FB_H     = 120,
  parameter int                 ADDR_W   = 15,
  parameter int                 COLOR_W  = 3,
  parameter int                 BRUSH_L  = 5,
  parameter logic [COLOR_W-1:0] BG_COLOR = 3'b111
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               pos_valid,
  input  logic [9:0]         x_pos,
  input  logic [9:0]         y_pos,
  input  logic               tool_on,
  input  logic               eraser,
  input  logic               size_big,
  input  logic [COLOR_W-1:0] color,
  input  logic               clear_req,
  input  logic               vga_rd_req,
  input  logic [ADDR_W-1:0]  vga_rd_addr,
  output logic [COLOR_W-1:0] vga_rd_data,
  output logic               vga_rd_valid,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_we,
  output logic [COLOR_W-1:0] mem_wdata,
  input  logic [COLOR_W-1:0] mem_rdata,
  output logic               busy,
  output logic [7:0]         drop_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_STAMP = 2'd1;
  localparam logic [1:0] S_CLEAR = 2'd2;

  localparam logic signed [10:0] R_BIG    = 11'((BRUSH_L - 1) / 2);
  localparam logic signed [10:0] W_S      = 11'(FB_W);
  localparam logic signed [10:0] H_S      = 11'(FB_H);
  localparam logic [ADDR_W-1:0]  LAST_PIX = ADDR_W'(FB_W * FB_H - 1);

  logic [1:0]          state_q, state_d;
  logic [9:0]          cx_q, cx_d, cy_q, cy_d;
  logic signed [10:0]  r_q, r_d, dx_q, dx_d, dy_q, dy_d;
  logic [COLOR_W-1:0]  wcol_q, wcol_d;
  logic [ADDR_W-1:0]   caddr_q, caddr_d;
  logic                clear_pend_q, clear_pend_d;
  logic [7:0]          drop_q, drop_d;
  logic                vga_valid_q;
  logic [COLOR_W-1:0]  vga_data_q;

  logic signed [10:0]  px, py;
  logic [ADDR_W-1:0]   stamp_addr;
  logic                in_bounds, granted, stamp_last, want_clear, drop_pulse;

  assign px         = $signed({1'b0, cx_q}) + dx_q;
  assign py         = $signed({1'b0, cy_q}) + dy_q;
  assign in_bounds  = !px[10] && !py[10] && (px < W_S) && (py < H_S);
  assign stamp_addr = ADDR_W'(py[9:0]) * ADDR_W'(FB_W) + ADDR_W'(px[9:0]);
  assign granted    = !vga_rd_req;
  assign stamp_last = (dx_q == r_q) && (dy_q == r_q);
  assign want_clear = clear_req || clear_pend_q;
  // A clear winning arbitration in IDLE also drops a same-cycle paint sample.
  assign drop_pulse = pos_valid && tool_on && ((state_q != S_IDLE) || want_clear);

  always_comb begin
    state_d      = state_q;
    cx_d         = cx_q;
    cy_d         = cy_q;
    r_d          = r_q;
    dx_d         = dx_q;
    dy_d         = dy_q;
    wcol_d       = wcol_q;
    caddr_d      = caddr_q;
    clear_pend_d = clear_pend_q;
    drop_d       = (drop_pulse && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;
    case (state_q)
      S_IDLE: begin
        if (want_clear) begin
          state_d      = S_CLEAR;
          caddr_d      = '0;
          clear_pend_d = 1'b0;
        end else if (pos_valid && tool_on) begin
          state_d = S_STAMP;
          cx_d    = x_pos;
          cy_d    = y_pos;
          r_d     = size_big ? R_BIG : 11'sd0;
          dx_d    = -r_d;
          dy_d    = -r_d;
          wcol_d  = eraser ? BG_COLOR : color;
        end
      end
      S_STAMP: begin
        if (clear_req) clear_pend_d = 1'b1;
        // Off-canvas offsets never touch the port, so they skip ahead even while VGA owns it.
        if (!in_bounds || granted) begin
          if (stamp_last) begin
            if (want_clear) begin
              state_d      = S_CLEAR;
              caddr_d      = '0;
              clear_pend_d = 1'b0;
            end else begin
              state_d = S_IDLE;
            end
          end else if (dx_q == r_q) begin
            dx_d = -r_q;
            dy_d = dy_q + 11'sd1;
          end else begin
            dx_d = dx_q + 11'sd1;
          end
        end
      end
      S_CLEAR: begin
        if (granted) begin
          if (caddr_q == LAST_PIX) state_d = S_IDLE;
          else                     caddr_d = caddr_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q      <= S_IDLE;
      cx_q         <= '0;
      cy_q         <= '0;
      r_q          <= '0;
      dx_q         <= '0;
      dy_q         <= '0;
      wcol_q       <= '0;
      caddr_q      <= '0;
      clear_pend_q <= 1'b0;
      drop_q       <= '0;
      vga_valid_q  <= 1'b0;
      vga_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      r_q          <= r_d;
      dx_q         <= dx_d;
      dy_q         <= dy_d;
      wcol_q       <= wcol_d;
      caddr_q      <= caddr_d;
      clear_pend_q <= clear_pend_d;
      drop_q       <= drop_d;
      vga_valid_q  <= vga_rd_req;
      if (vga_valid_q) vga_data_q <= mem_rdata;
    end
  end

  // RAM output is already registered; hold the last word once valid drops.
  assign vga_rd_data  = vga_valid_q ? mem_rdata : vga_data_q;
  assign vga_rd_valid = vga_valid_q;
  assign busy         = (state_q != S_IDLE);
  assign drop_cnt     = drop_q;
  assign mem_we       = granted && (((state_q == S_STAMP) && in_bounds) || (state_q == S_CLEAR));

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    if (vga_rd_req)                mem_addr = vga_rd_addr;
    else if (state_q == S_STAMP)   mem_addr = stamp_addr;
    else if (state_q == S_CLEAR)   mem_addr = caddr_q;
    if (state_q == S_STAMP)        mem_wdata = wcol_q;
    else if (state_q == S_CLEAR)   mem_wdata = BG_COLOR;
  end

endmodule

// File: tb/tb_brush_stamp_ctrl.sv
// tb/tb_brush_stamp_ctrl.sv - randomized self-checking bench for brush_stamp_ctrl
`timescale 1ns/1ps
module tb_brush_stamp_ctrl;

  logic        clk = 1'b0;
  logic        clr;
  logic        pos_valid, tool_on, eraser, size_big, clear_req, vga_rd_req;
  logic [9:0]  x_pos, y_pos;
  logic [2:0]  color;
  logic [14:0] vga_rd_addr;
  logic [2:0]  vga_rd_data, mem_wdata, mem_rdata;
  logic        vga_rd_valid, mem_we, busy;
  logic [14:0] mem_addr;
  logic [7:0]  drop_cnt;

  logic        pre_en;
  logic [14:0] pre_addr;
  logic [2:0]  pre_data;
  logic [2:0]  ram [0:32767];

  int n_cmp = 0;
  int n_err = 0;

  int q_addr[$];
  bit q_we[$];
  int q_data[$];

  brush_stamp_ctrl dut (
    .clk(clk), .clr(clr), .pos_valid(pos_valid), .x_pos(x_pos), .y_pos(y_pos),
    .tool_on(tool_on), .eraser(eraser), .size_big(size_big), .color(color),
    .clear_req(clear_req), .vga_rd_req(vga_rd_req), .vga_rd_addr(vga_rd_addr),
    .vga_rd_data(vga_rd_data), .vga_rd_valid(vga_rd_valid), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_en)      ram[pre_addr] <= pre_data;
    else if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  logic       prev_req = 1'b0;
  logic [2:0] prev_exp = 3'd0;
  always @(negedge clk) begin
    if (!clr) prev_req = 1'b0;
    else begin
      check("vga_valid", vga_rd_valid, prev_req);
      if (prev_req) check("vga_data", vga_rd_data, prev_exp);
      prev_req = vga_rd_req;
      prev_exp = ram[vga_rd_addr];
    end
  end

  // Expected visit list: every brush offset in row-major order, flagged by whether it lands on canvas.
  task automatic model_stamp(input int x, input int y, input bit big, input bit er, input int col);
    int r, px, py;
    r = big ? 2 : 0;
    for (int dy = -r; dy <= r; dy++)
      for (int dx = -r; dx <= r; dx++) begin
        px = x + dx;
        py = y + dy;
        q_we.push_back(px >= 0 && px < 160 && py >= 0 && py < 120);
        q_addr.push_back(py * 160 + px);
        q_data.push_back(er ? 7 : col);
      end
  endtask

  task automatic model_clear();
    for (int a = 0; a < 19200; a++) begin
      q_we.push_back(1'b1);
      q_addr.push_back(a);
      q_data.push_back(7);
    end
  endtask

  task automatic pulse(input int x, input int y, input bit big, input bit er, input int col);
    x_pos = 10'(x); y_pos = 10'(y); size_big = big; eraser = er; color = 3'(col);
    pos_valid = 1'b1; tool_on = 1'b1;
    @(negedge clk);
    check("busy_at_pulse", busy, 1'b0);
    check("we_at_pulse", mem_we, 1'b0);
    @(posedge clk); #1;
    pos_valid = 1'b0;
  endtask

  // vga_mode: 0 none, 1 random, 2 held for loop cycles 5..7 at address 7
  task automatic run_ops(input int vga_mode, input int clr_at, input int drops_from,
                         input int drops_n, output int cycles);
    int  idx = 0;
    int  cyc = 0;
    bit  req, exp_we;
    while (idx < q_addr.size()) begin
      case (vga_mode)
        1:       begin req = ($urandom_range(0, 3) == 0); vga_rd_addr = 15'($urandom_range(0, 19199)); end
        2:       begin req = (cyc >= 5 && cyc <= 7); vga_rd_addr = 15'd7; end
        default: req = 1'b0;
      endcase
      vga_rd_req = req;
      clear_req  = (cyc == clr_at);
      pos_valid  = (cyc >= drops_from && cyc < drops_from + drops_n);
      tool_on    = 1'b1;
      @(negedge clk);
      check("busy", busy, 1'b1);
      exp_we = q_we[idx] && !req;
      check("mem_we", mem_we, exp_we);
      if (exp_we) begin
        check("mem_addr", mem_addr, q_addr[idx]);
        check("mem_wdata", mem_wdata, q_data[idx]);
      end
      if (req) check("vga_addr_mux", mem_addr, vga_rd_addr);
      if (!(q_we[idx] && req)) idx++;
      cyc++;
      @(posedge clk); #1;
    end
    vga_rd_req = 1'b0; clear_req = 1'b0; pos_valid = 1'b0;
    @(negedge clk);
    check("busy_end", busy, 1'b0);
    check("we_end", mem_we, 1'b0);
    @(posedge clk); #1;
    cycles = cyc;
    q_addr.delete(); q_we.delete(); q_data.delete();
  endtask

  initial begin
    int cyc, w, x, y;
    bit big, er;
    clr = 1'b0; pos_valid = 1'b0; tool_on = 1'b0; eraser = 1'b0; size_big = 1'b0;
    clear_req = 1'b0; vga_rd_req = 1'b0; x_pos = '0; y_pos = '0; color = '0;
    vga_rd_addr = '0; pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_we", mem_we, 1'b0);
    check("rst_addr", mem_addr, 15'd0);
    check("rst_wdata", mem_wdata, 3'd0);
    check("rst_vga_valid", vga_rd_valid, 1'b0);
    check("rst_vga_data", vga_rd_data, 3'd0);
    check("rst_drop", drop_cnt, 8'd0);
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;

    model_stamp(10, 20, 0, 0, 4);
    pulse(10, 20, 0, 0, 4);
    run_ops(0, -1, 0, 0, cyc);
    check("small_cycles", cyc, 1);

    model_stamp(0, 0, 1, 1, 2);
    pulse(0, 0, 1, 1, 2);
    run_ops(0, -1, 0, 0, cyc);
    check("corner_cycles", cyc, 25);

    pre_en = 1'b1; pre_addr = 15'd7; pre_data = 3'd2;
    @(posedge clk); #1;
    pre_en = 1'b0;
    model_stamp(100, 50, 1, 0, 5);
    pulse(100, 50, 1, 0, 5);
    run_ops(2, -1, 0, 0, cyc);
    check("vga_stall_cycles", cyc, 28);

    for (int i = 0; i < 30; i++) begin
      x = ($urandom_range(0, 7) == 0) ? 1023 : $urandom_range(0, 165);
      y = ($urandom_range(0, 7) == 0) ? 1023 : $urandom_range(0, 125);
      big = 1'($urandom_range(0, 1));
      er  = 1'($urandom_range(0, 1));
      w   = $urandom_range(0, 7);
      model_stamp(x, y, big, er, w);
      pulse(x, y, big, er, w);
      run_ops(1, -1, 0, 0, cyc);
    end

    model_stamp(80, 60, 1, 0, 3);
    model_clear();
    pulse(80, 60, 1, 0, 3);
    run_ops(0, 10, 40, 300, cyc);
    check("stamp_clear_cycles", cyc, 25 + 19200);
    check("drop_sat", drop_cnt, 8'd255);

    x_pos = 10'd5; y_pos = 10'd5; size_big = 1'b0; pos_valid = 1'b1; tool_on = 1'b0;
    @(posedge clk); #1;
    pos_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("tool_off_busy", busy, 1'b0);
      check("tool_off_we", mem_we, 1'b0);
    end
    @(posedge clk); #1;

    pulse(100, 50, 1, 0, 1);
    w = 0;
    for (int i = 0; i < 100 && w < 10; i++) begin
      @(negedge clk);
      if (mem_we) w++;
      @(posedge clk); #1;
    end
    check("writes_before_reset", w, 10);
    clr = 1'b0;
    #1;
    check("midrst_we", mem_we, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_drop", drop_cnt, 8'd0);
    @(posedge clk); #1;
    clr = 1'b1;
    repeat (30) begin
      @(negedge clk);
      check("post_rst_we", mem_we, 1'b0);
      check("post_rst_busy", busy, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
